// File: rtl/hex_disp_pkg.sv
// Shared register map, control bit positions and 7-segment decode table
// for the hex display bank.
package hex_disp_pkg;

  localparam logic [3:0] ADDR_BLANK = 4'd8;
  localparam logic [3:0] ADDR_BLINK = 4'd9;
  localparam logic [3:0] ADDR_CTRL  = 4'd10;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_RESYNC_BIT = 1;
  localparam int CTRL_PHASE_BIT  = 2;

  // Active-high patterns, segment a in bit 0; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-high 7-segment pattern decoder.
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/hex_disp_bank.sv
// Multi-digit 7-segment display bank with an Avalon-MM register interface,
// per-digit raw/decode mode, blank and blink masks, and selectable polarity.
module hex_disp_bank
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int BLINK_DIV      = 25000000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [7:0]              writedata,
  output logic [7:0]              readdata,
  output logic [NUM_DIGITS*7-1:0] seg_out,
  output logic                    blink_phase
);

  localparam int SEG_W = NUM_DIGITS * 7;
  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SEG_W-1:0] SEG_DARK = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  logic [7:0]            r_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_blank;
  logic [NUM_DIGITS-1:0] r_blink;
  logic                  r_en;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_phase;
  logic [SEG_W-1:0]      r_seg;

  logic                  w_wr;
  logic                  w_resync;
  logic [SEG_W-1:0]      w_segNext;

  assign w_wr     = chipselect && !write_n;
  assign w_resync = w_wr && (address == ADDR_CTRL) && writedata[CTRL_RESYNC_BIT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= 8'h00;
      r_blank <= '0;
      r_blink <= '0;
      r_en    <= 1'b1;
    end else if (w_wr) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (address == 4'(k)) r_digit[k] <= writedata;
      end
      if (address == ADDR_BLANK) r_blank <= writedata[NUM_DIGITS-1:0];
      if (address == ADDR_BLINK) r_blink <= writedata[NUM_DIGITS-1:0];
      if (address == ADDR_CTRL)  r_en    <= writedata[CTRL_EN_BIT];
    end
  end

  // Free-running blink timer; a resync write wins over a coincident wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_resync) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [6:0] w_dec;
    logic [6:0] w_pat;
    logic       w_lit;

    hex_seg_decode u_dec (
      .i_nibble (r_digit[k][3:0]),
      .o_seg    (w_dec)
    );

    assign w_pat = r_digit[k][7] ? w_dec : r_digit[k][6:0];
    assign w_lit = r_en && !r_blank[k] && !(r_blink[k] && r_phase);
    assign w_segNext[7*k +: 7] = w_lit ? w_pat : 7'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_seg <= SEG_DARK;
    else          r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_segNext : w_segNext;
  end

  always_comb begin
    readdata = 8'h00;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (address == 4'(k)) readdata = r_digit[k];
    end
    if (address == ADDR_BLANK) readdata[NUM_DIGITS-1:0] = r_blank;
    if (address == ADDR_BLINK) readdata[NUM_DIGITS-1:0] = r_blink;
    if (address == ADDR_CTRL) begin
      readdata[CTRL_EN_BIT]    = r_en;
      readdata[CTRL_PHASE_BIT] = r_phase;
    end
  end

  assign seg_out     = r_seg;
  assign blink_phase = r_phase;

endmodule

// File: tb/tb_hex_disp_bank.sv
// Self-checking bench for hex_disp_bank: directed register writes compared
// every cycle against a cycle-count based display model.
module tb_hex_disp_bank;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [3:0]    address = 4'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [7:0]    writedata = 8'h00;
  logic [7:0]    readdata;
  logic [ND*7-1:0] seg_out;
  logic          blink_phase;

  int checks = 0;
  int failures = 0;
  bit compareOn = 1'b0;

  logic [6:0] DECODE [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [7:0]  mDigit [ND];
  logic [ND-1:0] mBlank = '0;
  logic [ND-1:0] mBlink = '0;
  logic        mEn = 1'b1;
  int          mT = 0;
  logic [27:0] expSeg = 28'hFFFFFFF;
  logic        expPhase = 1'b0;

  hex_disp_bank #(.NUM_DIGITS(ND), .BLINK_DIV(DIV), .SEG_ACTIVE_LOW(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .seg_out     (seg_out),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  function automatic logic modelPhase();
    return ((mT / DIV) % 2) == 1;
  endfunction

  function automatic logic [27:0] modelSeg();
    logic [27:0] lit = '0;
    for (int k = 0; k < ND; k++) begin
      logic [6:0] pat = mDigit[k][7] ? DECODE[mDigit[k][3:0]] : mDigit[k][6:0];
      if (mEn && !mBlank[k] && !(mBlink[k] && modelPhase())) lit[7*k +: 7] = pat;
    end
    return ~lit;
  endfunction

  function automatic logic [7:0] readModel(input logic [3:0] a);
    if (a < 4'(ND)) return mDigit[a];
    case (a)
      4'd8:    return {4'b0, mBlank};
      4'd9:    return {4'b0, mBlink};
      4'd10:   return {5'b0, modelPhase(), 1'b0, mEn};
      default: return 8'h00;
    endcase
  endfunction

  // Model: each edge registers the display of the pre-edge state, then applies the bus write.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < ND; k++) mDigit[k] = 8'h00;
      mBlank = '0; mBlink = '0; mEn = 1'b1; mT = 0;
      expSeg = 28'hFFFFFFF; expPhase = 1'b0;
    end else begin
      expSeg = modelSeg();
      if (chipselect && !write_n) begin
        if (address < 4'(ND)) mDigit[address] = writedata;
        if (address == 4'd8) mBlank = writedata[ND-1:0];
        if (address == 4'd9) mBlink = writedata[ND-1:0];
        if (address == 4'd10) mEn = writedata[0];
      end
      if (chipselect && !write_n && address == 4'd10 && writedata[1]) mT = 0;
      else mT = mT + 1;
      expPhase = modelPhase();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("seg_model", 32'(seg_out), 32'(expSeg));
      checkOutput("phase_model", 32'(blink_phase), 32'(expPhase));
    end
  end

  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic readCheck(input logic [3:0] a, input string name);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 checkOutput(name, 32'(readdata), 32'(readModel(a)));
    chipselect = 1'b0;
  endtask

  task automatic readLiteral(input logic [3:0] a, input logic [7:0] exp, input string name);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 checkOutput(name, 32'(readdata), 32'(exp));
    chipselect = 1'b0;
  endtask

  initial begin
    bit prev;
    bit found;
    #1 reset_n = 1'b0;
    compareOn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_seg", 32'(seg_out), 32'h0FFFFFFF);
    readLiteral(4'd10, 8'h01, "reset_ctrl");
    reset_n = 1'b1;
    for (int a = 0; a < ND; a++) readLiteral(4'(a), 8'h00, "reset_digit");

    applyStimulus(4'd0, 8'h85);
    applyStimulus(4'd1, 8'h3F);
    @(negedge clk);
    checkOutput("dig0_dec5", 32'(seg_out[6:0]), 32'h12);
    checkOutput("dig1_raw", 32'(seg_out[13:7]), 32'h40);
    readCheck(4'd0, "read_dig0");

    applyStimulus(4'd8, 8'h01);
    @(negedge clk);
    checkOutput("blank_dig0", 32'(seg_out[6:0]), 32'h7F);
    applyStimulus(4'd8, 8'h00);
    @(negedge clk);
    checkOutput("unblank_dig0", 32'(seg_out[6:0]), 32'h12);

    applyStimulus(4'd9, 8'h02);
    applyStimulus(4'd10, 8'h03);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("blink_dig1", 32'(seg_out[13:7]), (i < 4) ? 32'h40 : 32'h7F);
      checkOutput("blink_phase", 32'(blink_phase), (((i + 1) / 4) % 2 == 1) ? 32'h1 : 32'h0);
      readLiteral(4'd10, (((i + 1) / 4) % 2 == 1) ? 8'h05 : 8'h01, "ctrl_phase");
    end

    found = 1'b0;
    prev = blink_phase;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (blink_phase && !prev) found = 1'b1;
      prev = blink_phase;
    end
    checkOutput("wait_dark_phase", 32'(found), 32'h1);
    applyStimulus(4'd10, 8'h03);
    checkOutput("resync_phase", 32'(blink_phase), 32'h0);
    checkOutput("resync_still_dark", 32'(seg_out[13:7]), 32'h7F);
    @(negedge clk);
    checkOutput("resync_visible", 32'(seg_out[13:7]), 32'h40);

    applyStimulus(4'd10, 8'h00);
    @(negedge clk);
    checkOutput("en_off_dark", 32'(seg_out), 32'h0FFFFFFF);
    readCheck(4'd0, "en_off_keep_dig0");
    readCheck(4'd10, "en_off_ctrl");
    applyStimulus(4'd10, 8'h01);
    @(negedge clk);
    checkOutput("en_on_dig0", 32'(seg_out[6:0]), 32'h12);

    applyStimulus(4'd5, 8'hAA);
    applyStimulus(4'd15, 8'hFF);
    applyStimulus(4'd2, 8'h8A);
    applyStimulus(4'd3, 8'h0E);
    @(negedge clk);
    checkOutput("dig2_decA", 32'(seg_out[20:14]), 32'h08);
    checkOutput("dig3_raw", 32'(seg_out[27:21]), 32'h71);
    readLiteral(4'd5, 8'h00, "read_addr5");
    readLiteral(4'd15, 8'h00, "read_addr15");
    readLiteral(4'd4, 8'h00, "read_addr4");
    readLiteral(4'd9, 8'h02, "read_blink");
    for (int a = 0; a < 16; a++) readCheck(4'(a), "read_model");

    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_seg", 32'(seg_out), 32'h0FFFFFFF);
    checkOutput("async_reset_phase", 32'(blink_phase), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    readLiteral(4'd1, 8'h00, "post_reset_dig1");
    readLiteral(4'd9, 8'h00, "post_reset_blink");
    repeat (10) @(negedge clk);
    compareOn = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
